// File: rtl/cdb_pkg.sv
// Shared CDB write-back definitions: default widths, broadcast bus type, source indices.
package cdb_pkg;
  localparam int CDB_NUM_SRC = 3;
  localparam int CDB_TAG_W   = 3;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_SRC_W   = $clog2(CDB_NUM_SRC);

  localparam int SRC_RES1_U0 = 0;
  localparam int SRC_RES1_U1 = 1;
  localparam int SRC_RES2    = 2;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_bus_t;
endpackage

// File: rtl/cdb_rr_picker.sv
// One-hot request picker: round-robin from ptr, or lowest-index-first when
// CDB_FIXED_PRIO_EN is defined (ptr is then ignored).
module cdb_rr_picker #(
  parameter int NUM_SRC = 3,
  parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);
`ifdef CDB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
`ifdef CDB_FIXED_PRIO_EN
      j = k;
`else
      j = (int'(ptr) + k) % NUM_SRC;
`endif
      if (req[j] && !any) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = SRC_W'(j);
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmitter: per-source one-entry result buffers arbitrated onto a registered
// broadcast bus. Define CDB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);
  logic [NUM_SRC-1:0]             hold_v, grant, accept;
  logic [NUM_SRC-1:0][TAG_W-1:0]  hold_tag;
  logic [NUM_SRC-1:0][DATA_W-1:0] hold_data;
  logic [SRC_W-1:0]               pick_ptr, gnt_idx;
  logic                           gnt_any;

  // A buffer being granted frees this cycle, so it can reload back-to-back.
  assign src_ready = ~hold_v | grant;
  assign accept    = src_valid & src_ready;

  cdb_rr_picker #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_pick (
    .req   (hold_v),
    .ptr   (pick_ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

`ifdef CDB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [SRC_W-1:0] rr_ptr;
  assign pick_ptr = rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_ptr <= '0;
    else if (flush)   rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= (gnt_idx == SRC_W'(NUM_SRC-1)) ? '0 : gnt_idx + SRC_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v    <= '0;
      hold_tag  <= '0;
      hold_data <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (flush) begin
          hold_v[i] <= 1'b0;
        end else if (accept[i]) begin
          hold_v[i]    <= 1'b1;
          hold_tag[i]  <= src_tag[i*TAG_W +: TAG_W];
          hold_data[i] <= src_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

  // Payload fields hold across idle cycles; only valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (gnt_any) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= hold_tag[gnt_idx];
      cdb_data  <= hold_data[gnt_idx];
      cdb_src   <= gnt_idx;
    end else begin
      cdb_valid <= 1'b0;
    end
  end
endmodule
